// File: rtl/mcp3202_pkg.sv
// Shared types and constants for the MCP3202 device-side SPI emulation.
// Holds the responder state encoding, result width, command bit order and the channel mux rule.
package mcp3202_pkg;

   localparam int ADC_BITS = 12;

   localparam int CMD_START = 0;
   localparam int CMD_SGL   = 1;
   localparam int CMD_ODD   = 2;
   localparam int CMD_MSBF  = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_START,
      ST_CMD,
      ST_NULL,
      ST_MSB_OUT,
      ST_LSB_OUT,
      ST_TAIL
   } state_e;

   // Differential modes subtract at 13 bits so a negative difference can be detected and clamped to zero.
   function automatic logic [ADC_BITS-1:0] chan_mux(
      input logic                sgl,
      input logic                odd,
      input logic [ADC_BITS-1:0] ch0,
      input logic [ADC_BITS-1:0] ch1
   );
      logic [ADC_BITS:0]   diff;
      logic [ADC_BITS-1:0] result;
      diff = '0;
      if (sgl) begin
         result = odd ? ch1 : ch0;
      end else begin
         diff   = odd ? ({1'b0, ch1} - {1'b0, ch0}) : ({1'b0, ch0} - {1'b0, ch1});
         result = diff[ADC_BITS] ? '0 : diff[ADC_BITS-1:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/mcp3202_spi_responder_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input with a chosen reset level.
// Rise/fall pulses come from comparing the synchronized level against its previous sample.
module sync_edge_det #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = sync_q[STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/mcp3202_spi_responder.sv
// Device side of the MCP3202 serial protocol: decodes start/SGL/ODD/MSBF and shifts a 12-bit
// result (null bit, MSB-first, optional LSB-first repeat) on MISO, all in the clk domain.
module mcp3202_spi_responder
   import mcp3202_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                sck_i,
   input  logic                cs_n_i,
   input  logic                mosi_i,
   input  logic [ADC_BITS-1:0] ch0_data_i,
   input  logic [ADC_BITS-1:0] ch1_data_i,
   output logic                miso_o,
   output logic                miso_oe_o,
   output logic                cmd_valid_o,
   output logic                cmd_sgl_o,
   output logic                cmd_odd_o,
   output logic                cmd_msbf_o,
   output logic [ADC_BITS-1:0] sample_o,
   output logic                xfer_done_o,
   output logic                abort_o
);

   logic sckLvl, sckRise, sckFall;
   logic csLvl, csRise, csFall;
   logic mosiLvl, mosiRise, mosiFall;
   logic unusedSyncOutputs;

   sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uSyncSck (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (sck_i),
      .level_o (sckLvl),
      .rise_o  (sckRise),
      .fall_o  (sckFall)
   );

   sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uSyncCs (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (cs_n_i),
      .level_o (csLvl),
      .rise_o  (csRise),
      .fall_o  (csFall)
   );

   sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncMosi (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (mosi_i),
      .level_o (mosiLvl),
      .rise_o  (mosiRise),
      .fall_o  (mosiFall)
   );

   assign unusedSyncOutputs = ^{sckLvl, csLvl, mosiRise, mosiFall};

   state_e              state_q;
   logic [1:0]          cmdIdx_q;
   logic [3:0]          bitIdx_q;
   logic                sgl_q, odd_q, msbf_q;
   logic [ADC_BITS-1:0] sample_q, sample_d;
   logic                bit_q, miso_q, oe_q;
   logic                cmdValid_q, xferDone_q, abort_q;
   logic                b0Done_q;

   // SGL and ODD are already registered when the MSBF rise arrives, so the mux can use them directly.
   assign sample_d = chan_mux(sgl_q, odd_q, ch0_data_i, ch1_data_i);

   // bit_q is the FSM's choice of MISO level; miso_q adds one output stage and is forced low on release.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cmdIdx_q   <= '0;
         bitIdx_q   <= '0;
         sgl_q      <= 1'b0;
         odd_q      <= 1'b0;
         msbf_q     <= 1'b0;
         sample_q   <= '0;
         bit_q      <= 1'b0;
         miso_q     <= 1'b0;
         oe_q       <= 1'b0;
         cmdValid_q <= 1'b0;
         xferDone_q <= 1'b0;
         abort_q    <= 1'b0;
         b0Done_q   <= 1'b0;
      end else begin
         cmdValid_q <= 1'b0;
         xferDone_q <= 1'b0;
         abort_q    <= 1'b0;
         miso_q     <= csRise ? 1'b0 : bit_q;
         if (csRise && (state_q != ST_IDLE)) begin
            state_q    <= ST_IDLE;
            oe_q       <= 1'b0;
            bit_q      <= 1'b0;
            xferDone_q <= b0Done_q;
            abort_q    <= ~b0Done_q;
            b0Done_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  oe_q  <= 1'b0;
                  bit_q <= 1'b0;
                  if (csFall) begin
                     state_q  <= ST_WAIT_START;
                     b0Done_q <= 1'b0;
                  end
               end
               ST_WAIT_START: begin
                  if (sckRise && mosiLvl) begin
                     state_q  <= ST_CMD;
                     cmdIdx_q <= 2'(CMD_SGL);
                  end
               end
               ST_CMD: begin
                  if (sckRise) begin
                     if (cmdIdx_q == 2'(CMD_MSBF)) begin
                        msbf_q     <= mosiLvl;
                        sample_q   <= sample_d;
                        cmdValid_q <= 1'b1;
                        state_q    <= ST_NULL;
                     end else begin
                        if (cmdIdx_q == 2'(CMD_SGL)) begin
                           sgl_q <= mosiLvl;
                        end else begin
                           odd_q <= mosiLvl;
                        end
                        cmdIdx_q <= cmdIdx_q + 2'd1;
                     end
                  end
               end
               ST_NULL: begin
                  if (sckFall) begin
                     oe_q     <= 1'b1;
                     bit_q    <= 1'b0;
                     bitIdx_q <= 4'(ADC_BITS - 1);
                     state_q  <= ST_MSB_OUT;
                  end
               end
               ST_MSB_OUT: begin
                  if (sckFall) begin
                     bit_q <= sample_q[bitIdx_q];
                     if (bitIdx_q == 4'd0) begin
                        b0Done_q <= 1'b1;
                        if (msbf_q) begin
                           state_q <= ST_TAIL;
                        end else begin
                           bitIdx_q <= 4'd1;
                           state_q  <= ST_LSB_OUT;
                        end
                     end else begin
                        bitIdx_q <= bitIdx_q - 4'd1;
                     end
                  end
               end
               ST_LSB_OUT: begin
                  if (sckFall) begin
                     bit_q <= sample_q[bitIdx_q];
                     if (bitIdx_q == 4'(ADC_BITS - 1)) begin
                        state_q <= ST_TAIL;
                     end else begin
                        bitIdx_q <= bitIdx_q + 4'd1;
                     end
                  end
               end
               ST_TAIL: begin
                  if (sckFall) begin
                     bit_q <= 1'b0;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign miso_o      = miso_q;
   assign miso_oe_o   = oe_q;
   assign cmd_valid_o = cmdValid_q;
   assign cmd_sgl_o   = sgl_q;
   assign cmd_odd_o   = odd_q;
   assign cmd_msbf_o  = msbf_q;
   assign sample_o    = sample_q;
   assign xfer_done_o = xferDone_q;
   assign abort_o     = abort_q;

endmodule

// File: tb/tb_mcp3202_spi_responder.sv
// Scoreboard bench for mcp3202_spi_responder: a mode-1,1 SPI master drives frames while monitors
// compare MISO bits, command decode and end-of-frame pulses against a protocol-level model.
module tb_mcp3202_spi_responder;

   logic        clk = 1'b0;
   logic        rst, sck, cs_n, mosi;
   logic [11:0] ch0, ch1;
   logic        miso, miso_oe, cmd_valid, cmd_sgl, cmd_odd, cmd_msbf, xfer_done, abort;
   logic [11:0] sample;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      bit sgl;
      bit odd;
      bit msbf;
      int smp;
   } cmd_t;

   cmd_t cmdQ[$];
   int   bitQ[$];
   bit   endQ[$];

   cmd_t expCmd;
   int   expBit;
   bit   expDone;

   always #5 clk = ~clk;

   mcp3202_spi_responder #(.SYNC_STAGES(2)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .sck_i       (sck),
      .cs_n_i      (cs_n),
      .mosi_i      (mosi),
      .ch0_data_i  (ch0),
      .ch1_data_i  (ch1),
      .miso_o      (miso),
      .miso_oe_o   (miso_oe),
      .cmd_valid_o (cmd_valid),
      .cmd_sgl_o   (cmd_sgl),
      .cmd_odd_o   (cmd_odd),
      .cmd_msbf_o  (cmd_msbf),
      .sample_o    (sample),
      .xfer_done_o (xfer_done),
      .abort_o     (abort)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Converted value the ADC would report for the command and channel values.
   function automatic int refSample(input bit sgl, input bit odd, input int c0, input int c1);
      int d;
      if (sgl) return odd ? c1 : c0;
      d = odd ? (c1 - c0) : (c0 - c1);
      return (d < 0) ? 0 : d;
   endfunction

   // Expected {oe, miso} at the j-th response rise (j < 0 means still in the command phase).
   function automatic int refMiso(input int j, input int smp, input bit msbf);
      if (j < 0) return 0;
      if (j == 0) return 2;
      if (j <= 12) return 2 + ((smp >> (12 - j)) & 1);
      if (msbf) return 2;
      if (j <= 23) return 2 + ((smp >> (j - 12)) & 1);
      return 2;
   endfunction

   task automatic checkResetState(input string name);
      checkOutput(name, 32'({miso, miso_oe, cmd_valid, cmd_sgl, cmd_odd, cmd_msbf, xfer_done, abort, sample}), 32'd0);
   endtask

   task automatic sckCycle(input bit b, input int h);
      @(negedge clk);
      sck  = 1'b0;
      mosi = b;
      repeat (h) @(negedge clk);
      sck = 1'b1;
      repeat (h - 1) @(negedge clk);
   endtask

   task automatic applyStimulus(input int lead, input bit sgl, input bit odd, input bit msbf,
                                input int nResp, input int h, input logic [11:0] c0,
                                input logic [11:0] c1, input bit midReset);
      int   smp;
      int   total;
      cmd_t c;
      bit   bits[$];
      @(negedge clk);
      ch0 = c0;
      ch1 = c1;
      smp = refSample(sgl, odd, int'(c0), int'(c1));
      c.sgl = sgl;
      c.odd = odd;
      c.msbf = msbf;
      c.smp = smp;
      cmdQ.push_back(c);
      for (int i = 0; i < lead; i++) bits.push_back(1'b0);
      bits.push_back(1'b1);
      bits.push_back(sgl);
      bits.push_back(odd);
      bits.push_back(msbf);
      for (int i = 0; i < nResp; i++) bits.push_back(1'($urandom_range(0, 1)));
      total = bits.size();
      for (int r = 0; r < total; r++) bitQ.push_back(refMiso(r - lead - 4, smp, msbf));
      if (!midReset) endQ.push_back(nResp >= 13);
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
      for (int r = 0; r < total; r++) begin
         sckCycle(bits[r], h);
         if (r == lead + 3) begin
            ch0 = 12'($urandom);
            ch1 = 12'($urandom);
         end
      end
      @(negedge clk);
      if (midReset) begin
         cs_n = 1'b1;
         rst  = 1'b1;
         @(negedge clk);
         rst = 1'b0;
      end else begin
         cs_n = 1'b1;
      end
      repeat (8) @(negedge clk);
      checkOutput("cmdValidCount", 32'(cmdQ.size()), 32'd0);
      checkOutput("misoBitCount", 32'(bitQ.size()), 32'd0);
      checkOutput("endPulseCount", 32'(endQ.size()), 32'd0);
      checkOutput("oeIdle", 32'(miso_oe), 32'd0);
      if (midReset) checkResetState("stateAfterMidReset");
      cmdQ.delete();
      bitQ.delete();
      endQ.delete();
   endtask

   // MISO monitor: the master samples on each sck rise.
   always @(posedge sck) begin
      if (cs_n === 1'b0) begin
         if (bitQ.size() == 0) begin
            checkOutput("unexpectedSckRise", 32'd1, 32'd0);
         end else begin
            expBit = bitQ.pop_front();
            checkOutput("misoBit", 32'({miso_oe, miso}), 32'(expBit));
         end
      end
   end

   // Pulse monitor for command decode and end-of-frame events.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (cmd_valid === 1'b1) begin
            if (cmdQ.size() == 0) begin
               checkOutput("unexpectedCmdValid", 32'd1, 32'd0);
            end else begin
               expCmd = cmdQ.pop_front();
               checkOutput("cmdSgl", 32'(cmd_sgl), 32'(expCmd.sgl));
               checkOutput("cmdOdd", 32'(cmd_odd), 32'(expCmd.odd));
               checkOutput("cmdMsbf", 32'(cmd_msbf), 32'(expCmd.msbf));
               checkOutput("sample", 32'(sample), 32'(expCmd.smp));
            end
         end
         if ((xfer_done === 1'b1) || (abort === 1'b1)) begin
            if (endQ.size() == 0) begin
               checkOutput("unexpectedEndPulse", 32'({xfer_done, abort}), 32'd0);
            end else begin
               expDone = endQ.pop_front();
               checkOutput("xferDone", 32'(xfer_done), 32'(expDone));
               checkOutput("abort", 32'(abort), 32'(!expDone));
               checkOutput("oeAtRelease", 32'(miso_oe), 32'd0);
            end
         end
      end
   end

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst  = 1'b1;
      sck  = 1'b1;
      cs_n = 1'b1;
      mosi = 1'b0;
      ch0  = '0;
      ch1  = '0;
      repeat (3) @(negedge clk);
      checkResetState("resetState");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checkResetState("idleAfterReset");

      applyStimulus(0, 1'b1, 1'b0, 1'b1, 13, 6, 12'hA5C, 12'h3C3, 1'b0);
      applyStimulus(0, 1'b0, 1'b0, 1'b1, 13, 6, 12'h100, 12'h300, 1'b0);
      applyStimulus(0, 1'b0, 1'b1, 1'b1, 13, 6, 12'h100, 12'h300, 1'b0);
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 26, 6, 12'h123, 12'h801, 1'b0);
      applyStimulus(3, 1'b1, 1'b0, 1'b1, 6, 6, 12'hFFF, 12'h000, 1'b0);
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 5, 6, 12'h5A5, 12'h7E1, 1'b1);
      applyStimulus(0, 1'b1, 1'b0, 1'b1, 13, 5, 12'hC3A, 12'h111, 1'b0);
      applyStimulus(1, 1'b0, 1'b1, 1'b0, 24, 5, 12'h000, 12'hFFF, 1'b0);

      for (int n = 0; n < 30; n++) begin
         applyStimulus($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 9) < 7) ? $urandom_range(13, 30) : $urandom_range(0, 12),
                       $urandom_range(5, 8), 12'($urandom), 12'($urandom), ($urandom_range(0, 9) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
